// File: rtl/led_rgb_seq_ctrl.sv
// RGB LED pattern sequencer: drives an AXI4-Lite LED core through a pattern table.
// Optional readback verification of each channel write is enabled by LED_SEQ_READBACK_EN.
module led_rgb_seq_ctrl #(
  parameter int unsigned STEPS     = 8,
  parameter logic [31:0] BLINK_DUR = 32'd50_000_000
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        start,
  input  logic        stop,
  input  logic [3:0]  num_steps,
  input  logic        hold_cfg,
  input  logic        tbl_we,
  input  logic [3:0]  tbl_addr,
  input  logic [29:0] tbl_data,
  output logic [4:0]  awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic [4:0]  araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic        busy,
  output logic [3:0]  step_idx,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int unsigned AW = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    CFG,
    STEP,
`ifdef LED_SEQ_READBACK_EN
    CHK,
`endif
    DWELL,
    SHUT
  } state_t;

  state_t      state;
  logic [29:0] tbl [STEPS];
  logic [29:0] cur;
  logic [23:0] cur_dwell;
  logic [2:0]  cur_mode;
  logic [2:0]  cur_en;
  logic [23:0] dwell_cnt;
  logic [1:0]  sub;
  logic        txn;
  logic        stop_pend;
  logic        stop_req;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  ns_eff;
  logic [3:0]  last_idx;
  logic [3:0]  nxt_idx;
`ifdef LED_SEQ_READBACK_EN
  logic        rd_txn;
  logic [2:0]  chk_exp;
`endif

  assign wstrb     = 4'hF;
  assign cur_dwell = cur[29:6];
  assign cur_mode  = cur[5:3];
  assign cur_en    = cur[2:0];
  assign stop_req  = stop | stop_pend;

  always_ff @(posedge aclk) begin
    if (tbl_we && (32'(tbl_addr) < STEPS))
      tbl[tbl_addr[AW-1:0]] <= tbl_data;
  end

  always_comb begin
    ns_eff = num_steps;
    if (num_steps == 4'd0)
      ns_eff = 4'd1;
    else if (32'(num_steps) > STEPS)
      ns_eff = 4'(STEPS);
    last_idx = ns_eff - 4'd1;
    nxt_idx  = (step_idx >= last_idx) ? 4'd0 : step_idx + 4'd1;
  end

  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    case (state)
      INIT: wr_data = 32'd1;
      CFG: begin
        wr_addr = 5'h08 + {sub, 3'b000};
        wr_data = BLINK_DUR;
      end
      STEP: begin
        wr_addr = 5'h04 + {sub, 3'b000};
        wr_data = {29'b0, hold_cfg, cur_en[sub], cur_mode[sub]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= IDLE;
      sub       <= '0;
      txn       <= 1'b0;
      stop_pend <= 1'b0;
      awaddr    <= '0;
      awvalid   <= 1'b0;
      wdata     <= '0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      araddr    <= '0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      busy      <= 1'b0;
      step_idx  <= '0;
      err       <= 1'b0;
      err_code  <= '0;
      cur       <= '0;
      dwell_cnt <= '0;
`ifdef LED_SEQ_READBACK_EN
      rd_txn    <= 1'b0;
      chk_exp   <= '0;
`endif
    end else begin
      if (stop && state != IDLE && state != SHUT)
        stop_pend <= 1'b1;
      if (awvalid && awready)
        awvalid <= 1'b0;
      if (wvalid && wready)
        wvalid <= 1'b0;
`ifndef LED_SEQ_READBACK_EN
      arvalid <= 1'b0;
      rready  <= 1'b1;
`endif
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state     <= INIT;
            busy      <= 1'b1;
            err       <= 1'b0;
            err_code  <= '0;
            step_idx  <= '0;
            stop_pend <= 1'b0;
            sub       <= '0;
          end
        end

        INIT, CFG, STEP, SHUT: begin
          if (!txn) begin
            if (state != SHUT && stop_req) begin
              state <= SHUT;
              sub   <= '0;
            end else begin
              awaddr  <= wr_addr;
              wdata   <= wr_data;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              bready  <= 1'b1;
              txn     <= 1'b1;
            end
          end else if (bvalid && bready) begin
            bready <= 1'b0;
            txn    <= 1'b0;
            if (bresp != 2'b00) begin
              err      <= 1'b1;
              err_code <= 2'b01;
            end
            if (state == SHUT) begin
              state     <= IDLE;
              busy      <= 1'b0;
              stop_pend <= 1'b0;
            end else if (stop_req) begin
              state <= SHUT;
              sub   <= '0;
            end else begin
              case (state)
                INIT: begin
                  state <= CFG;
                  sub   <= '0;
                end
                CFG: begin
                  if (sub == 2'd2) begin
                    state <= STEP;
                    sub   <= '0;
                    cur   <= tbl[step_idx[AW-1:0]];
                  end else begin
                    sub <= sub + 2'd1;
                  end
                end
                STEP: begin
`ifdef LED_SEQ_READBACK_EN
                  state   <= CHK;
                  chk_exp <= wdata[2:0];
`else
                  if (sub == 2'd2) begin
                    state     <= DWELL;
                    dwell_cnt <= (cur_dwell == '0) ? 24'd1 : cur_dwell;
                  end else begin
                    sub <= sub + 2'd1;
                  end
`endif
                end
                default: ;
              endcase
            end
          end
        end

`ifdef LED_SEQ_READBACK_EN
        CHK: begin
          if (!rd_txn) begin
            araddr  <= awaddr;
            arvalid <= 1'b1;
            rready  <= 1'b1;
            rd_txn  <= 1'b1;
          end else begin
            if (arvalid && arready)
              arvalid <= 1'b0;
            if (rvalid && rready) begin
              rready <= 1'b0;
              rd_txn <= 1'b0;
              if (rdata[2:0] != chk_exp || rresp != 2'b00) begin
                err      <= 1'b1;
                err_code <= 2'b10;
              end
              if (stop_req) begin
                state <= SHUT;
                sub   <= '0;
              end else if (sub == 2'd2) begin
                state     <= DWELL;
                dwell_cnt <= (cur_dwell == '0) ? 24'd1 : cur_dwell;
              end else begin
                state <= STEP;
                sub   <= sub + 2'd1;
              end
            end
          end
        end
`endif

        DWELL: begin
          if (stop_req) begin
            state <= SHUT;
            sub   <= '0;
          end else if (dwell_cnt <= 24'd1) begin
            step_idx <= nxt_idx;
            cur      <= tbl[nxt_idx[AW-1:0]];
            state    <= STEP;
            sub      <= '0;
          end else begin
            dwell_cnt <= dwell_cnt - 24'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_rgb_seq_ctrl.sv
// Directed bench for led_rgb_seq_ctrl with a small AXI4-Lite slave model and write log.
`timescale 1ns/1ps
module tb_led_rgb_seq_ctrl;

  localparam logic [31:0] BLINK = 32'hABCD_0123;

  logic        aclk = 1'b0;
  logic        areset;
  logic        start, stop, hold_cfg, tbl_we;
  logic [3:0]  num_steps, tbl_addr;
  logic [29:0] tbl_data;
  logic [4:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        busy, err;
  logic [3:0]  step_idx;
  logic [1:0]  err_code;

  led_rgb_seq_ctrl #(.STEPS(8), .BLINK_DUR(BLINK)) dut (
    .aclk(aclk), .areset(areset), .start(start), .stop(stop),
    .num_steps(num_steps), .hold_cfg(hold_cfg),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .busy(busy), .step_idx(step_idx), .err(err), .err_code(err_code)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // AXI4-Lite slave model
  logic        aw_hold = 1'b0;
  int          aw_delay = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic        corrupt = 1'b0;
  logic        got_aw, got_w, got_ar;
  logic [4:0]  cap_addr, cap_ar;
  logic [31:0] cap_data;
  int          aw_cnt;
  int          proto_err = 0;
  logic [31:0] mem [8];
  logic [4:0]  log_a [$];
  logic [31:0] log_d [$];

  always @(posedge aclk) begin
    if (areset) begin
      awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
      arready <= 1'b0; rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
      got_aw <= 1'b0; got_w <= 1'b0; got_ar <= 1'b0; aw_cnt <= 0;
      cap_addr <= '0; cap_data <= '0; cap_ar <= '0;
    end else begin
      awready <= 1'b0;
      wready  <= 1'b0;
      arready <= 1'b0;
      if ((awvalid && got_aw) || (wvalid && got_w))
        proto_err <= proto_err + 1;
      if (awvalid && awready) begin
        got_aw   <= 1'b1;
        cap_addr <= awaddr;
      end else if (awvalid && !awready && !got_aw && !aw_hold) begin
        if (aw_cnt >= aw_delay) begin
          awready <= 1'b1;
          aw_cnt  <= 0;
        end else begin
          aw_cnt <= aw_cnt + 1;
        end
      end
      if (wvalid && wready) begin
        got_w    <= 1'b1;
        cap_data <= wdata;
      end else if (wvalid && !wready && !got_w) begin
        wready <= 1'b1;
      end
      if (bvalid && bready) begin
        bvalid <= 1'b0;
        got_aw <= 1'b0;
        got_w  <= 1'b0;
      end else if (got_aw && got_w && !bvalid) begin
        bvalid <= 1'b1;
        bresp  <= bresp_cfg;
        mem[cap_addr[4:2]] <= cap_data;
        log_a.push_back(cap_addr);
        log_d.push_back(cap_data);
      end
      if (arvalid && arready) begin
        got_ar <= 1'b1;
        cap_ar <= araddr;
      end else if (arvalid && !arready && !got_ar) begin
        arready <= 1'b1;
      end
      if (rvalid && rready) begin
        rvalid <= 1'b0;
        got_ar <= 1'b0;
      end else if (got_ar && !rvalid) begin
        rvalid <= 1'b1;
        rresp  <= 2'b00;
        rdata  <= (corrupt && cap_ar == 5'h04) ? (mem[cap_ar[4:2]] & ~32'h2) : mem[cap_ar[4:2]];
      end
    end
  end

  // Monitor: dwell gap (B-write completion to next awvalid rise) and step index per R write
  int         gaps [$];
  logic [3:0] steps [$];
  int         cyc = 0;
  int         t_b = 0;
  bit         armed = 1'b0;
  logic       awv_d = 1'b0;

  always @(posedge aclk) begin
    cyc++;
    if (bvalid && bready && cap_addr == 5'h14) begin
      t_b   = cyc;
      armed = 1'b1;
    end
    if (armed && awvalid && !awv_d) begin
      gaps.push_back(cyc - t_b);
      armed = 1'b0;
    end
    if (awvalid && !awv_d && awaddr == 5'h04)
      steps.push_back(step_idx);
    awv_d = awvalid;
  end

  task automatic tbl_wr(input logic [3:0] a, input logic [23:0] dw,
                        input logic [2:0] mode, input logic [2:0] en);
    @(negedge aclk);
    tbl_we = 1'b1; tbl_addr = a; tbl_data = {dw, mode, en};
    @(negedge aclk);
    tbl_we = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge aclk); start = 1'b1;
    @(negedge aclk); start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge aclk); stop = 1'b1;
    @(negedge aclk); stop = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && log_a.size() < n; i++) @(negedge aclk);
    check(tag, 32'(log_a.size() >= n), 32'd1);
  endtask

  task automatic wait_steps(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && steps.size() < n; i++) @(negedge aclk);
    check(tag, 32'(steps.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    for (int i = 0; i < budget && busy; i++) @(negedge aclk);
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_awvalid(input int budget, input string tag);
    for (int i = 0; i < budget && !awvalid; i++) @(negedge aclk);
    check(tag, 32'(awvalid), 32'd1);
  endtask

  logic [4:0]  pat_a [10] = '{5'h00, 5'h08, 5'h10, 5'h18, 5'h04, 5'h0C, 5'h14, 5'h04, 5'h0C, 5'h14};
  logic [31:0] pat_d [10] = '{32'd1, BLINK, BLINK, BLINK, 32'd2, 32'd0, 32'd0, 32'd2, 32'd0, 32'd0};
  logic [3:0]  wrap_s [5] = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd1};
  int base, sb, gb, pe0;

  initial begin
    areset = 1'b1; start = 1'b0; stop = 1'b0; hold_cfg = 1'b0;
    num_steps = 4'd1; tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0;
    repeat (3) @(negedge aclk);

    // Reset state
    check("rst_awvalid", 32'(awvalid), 0);
    check("rst_wvalid", 32'(wvalid), 0);
    check("rst_bready", 32'(bready), 0);
    check("rst_rready", 32'(rready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_step", 32'(step_idx), 0);
    check("rst_err", {29'd0, err, err_code}, 0);
    check("rst_wstrb", 32'(wstrb), 32'hF);
    areset = 1'b0;
    repeat (2) @(negedge aclk);
`ifndef LED_SEQ_READBACK_EN
    check("idle_rready", 32'(rready), 1);
    check("idle_arvalid", 32'(arvalid), 0);
`endif

    // Pattern run: one step, dwell 10, red enabled
    tbl_wr(4'd0, 24'd10, 3'b000, 3'b001);
    num_steps = 4'd1; hold_cfg = 1'b0;
    base = log_a.size(); gb = gaps.size();
    pulse_start();
    check("pat_busy", 32'(busy), 1);
    wait_log(base + 10, 600, "pat_timeout");
    for (int i = 0; i < 10; i++) begin
      check("pat_addr", 32'(log_a[base+i]), 32'(pat_a[i]));
      check("pat_data", log_d[base+i], pat_d[i]);
    end
`ifndef LED_SEQ_READBACK_EN
    check("pat_dwell_gap", 32'(gaps[gb]), 32'd12);
`endif
    pulse_stop();
    wait_idle(200, "pat_idle");
    check("pat_shut_addr", 32'(log_a[log_a.size()-1]), 0);
    check("pat_shut_data", log_d[log_d.size()-1], 0);

    // Wrap over three zero-dwell steps
    tbl_wr(4'd0, 24'd0, 3'b000, 3'b001);
    tbl_wr(4'd1, 24'd0, 3'b010, 3'b111);
    tbl_wr(4'd2, 24'd0, 3'b100, 3'b100);
    num_steps = 4'd3; hold_cfg = 1'b1;
    base = log_a.size(); sb = steps.size(); gb = gaps.size();
    pulse_start();
    wait_steps(sb + 5, 800, "wrap_timeout");
    for (int i = 0; i < 5; i++)
      check("wrap_step", 32'(steps[sb+i]), 32'(wrap_s[i]));
    check("wrap_s1_g", log_d[base+8], 32'd7);
    check("wrap_s2_r", log_d[base+10], 32'd4);
    check("wrap_s2_b_addr", 32'(log_a[base+12]), 32'h14);
    check("wrap_s2_b", log_d[base+12], 32'd7);
`ifndef LED_SEQ_READBACK_EN
    check("wrap_dwell0_gap", 32'(gaps[gb]), 32'd3);
`endif
    pulse_stop();
    wait_idle(200, "wrap_idle");

    // num_steps above STEPS clamps to 8 entries
    for (int i = 3; i < 8; i++) tbl_wr(4'(i), 24'd0, 3'b000, 3'b000);
    num_steps = 4'd15;
    sb = steps.size();
    pulse_start();
    wait_steps(sb + 9, 2000, "clamp_timeout");
    check("clamp_step7", 32'(steps[sb+7]), 32'd7);
    check("clamp_wrap", 32'(steps[sb+8]), 32'd0);
    pulse_stop();
    wait_idle(200, "clamp_idle");

    // num_steps of 0 acts as 1
    num_steps = 4'd0;
    sb = steps.size();
    pulse_start();
    wait_steps(sb + 3, 600, "ns0_timeout");
    check("ns0_step1", 32'(steps[sb+1]), 0);
    check("ns0_step2", 32'(steps[sb+2]), 0);
    pulse_stop();
    wait_idle(200, "ns0_idle");
    num_steps = 4'd1; hold_cfg = 1'b0;

    // Stop while awready held low
    aw_hold = 1'b1;
    base = log_a.size();
    pulse_start();
    wait_awvalid(20, "stop_aw_timeout");
    pulse_stop();
    repeat (5) @(negedge aclk);
    check("stop_busy_hold", 32'(busy), 1);
    check("stop_no_write", 32'(log_a.size()), 32'(base));
    aw_hold = 1'b0;
    wait_idle(200, "stop_idle");
    check("stop_count", 32'(log_a.size()), 32'(base + 2));
    check("stop_w0_data", log_d[base], 32'd1);
    check("stop_w1_addr", 32'(log_a[base+1]), 0);
    check("stop_w1_data", log_d[base+1], 0);

    // start and stop together in IDLE: stop wins
    base = log_a.size();
    @(negedge aclk); start = 1'b1; stop = 1'b1;
    @(negedge aclk); start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge aclk);
    check("ss_busy", 32'(busy), 0);
    check("ss_nowrite", 32'(log_a.size()), 32'(base));

    // Backpressure (awready 5 cycles behind wready) with SLVERR responses
    aw_delay = 5; bresp_cfg = 2'b10;
    tbl_wr(4'd0, 24'd10, 3'b000, 3'b001);
    base = log_a.size(); pe0 = proto_err;
    pulse_start();
    wait_log(base + 7, 800, "bp_timeout");
    for (int i = 0; i < 7; i++)
      check("bp_addr", 32'(log_a[base+i]), 32'(pat_a[i]));
    check("bp_r_data", log_d[base+4], 32'd2);
    check("bp_err", 32'(err), 1);
    check("bp_err_code", 32'(err_code), 32'd1);
    check("bp_proto", 32'(proto_err - pe0), 0);
    pulse_stop();
    wait_idle(400, "bp_idle");
    check("bp_err_sticky", 32'(err), 1);

    // start clears the sticky error
    aw_delay = 0; bresp_cfg = 2'b00;
    pulse_start();
    check("clr_err", {29'd0, err, err_code}, 0);
    check("clr_busy", 32'(busy), 1);
    pulse_stop();
    wait_idle(200, "clr_idle");

`ifdef LED_SEQ_READBACK_EN
    // Readback mismatch on the red channel
    corrupt = 1'b1;
    pulse_start();
    for (int i = 0; i < 400 && !err; i++) @(negedge aclk);
    check("rb_err", 32'(err), 1);
    check("rb_err_code", 32'(err_code), 32'd2);
    pulse_stop();
    wait_idle(200, "rb_idle");
    corrupt = 1'b0;
`endif

    // Reset mid-write
    aw_hold = 1'b1;
    tbl_wr(4'd0, 24'd3, 3'b000, 3'b001);
    pulse_start();
    wait_awvalid(20, "mid_aw_timeout");
    @(negedge aclk); areset = 1'b1;
    @(posedge aclk); #1;
    check("mid_awvalid", 32'(awvalid), 0);
    check("mid_wvalid", 32'(wvalid), 0);
    check("mid_bready", 32'(bready), 0);
    check("mid_arvalid", 32'(arvalid), 0);
    check("mid_rready", 32'(rready), 0);
    check("mid_awaddr", {27'd0, awaddr}, 0);
    check("mid_araddr", {27'd0, araddr}, 0);
    check("mid_wdata", wdata, 0);
    check("mid_busy", 32'(busy), 0);
    check("mid_err", {25'd0, step_idx, err, err_code}, 0);
    @(negedge aclk); areset = 1'b0; aw_hold = 1'b0;
    repeat (3) @(negedge aclk);
    check("mid_idle_after", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
